thumb_imm_expander: RTL and testbench

THUMB_IMM_EXPANDER -- requirements
Module: thumb_imm_expander

---
 rtl/thumb_imm_expander.sv | 213 +++++++++++++++++++++
 tb/tb_thumb_imm_expander.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/thumb_imm_expander.sv
// thumb_imm_expander
// Extracts and expands the immediate field of a Thumb halfword stream into a
// DATA_W-bit value, one result per accepted halfword with one cycle of latency.
// 32-bit BL encodings are handled by holding the prefix halfword until its
// suffix arrives; pairing violations raise a one-cycle error pulse.
//
// Encoding overlap: the suffix pattern (11x1 in the top nibble) also covers
// the 16-bit conditional branch space (1101). With no prefix held, a halfword
// that has a valid 16-bit decode is taken as that decode, and only otherwise
// undecodable suffix patterns are reported as an orphan suffix. With a prefix
// held, the halfword is always taken as the second half of the 32-bit pair.
module thumb_imm_expander #(
    parameter int DATA_W     = 32,
    parameter bit ENABLE_T32 = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              instr_valid_i,
    input  logic [15:0]       instr_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic [DATA_W-1:0] imm_o,
    output logic              imm_valid_o,
    output logic [2:0]        imm_kind_o,
    output logic              t32_pending_o,
    output logic              err_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PAIR = 1'b1;

    localparam logic [2:0] KIND_NONE   = 3'd0;
    localparam logic [2:0] KIND_SHIFT  = 3'd1;
    localparam logic [2:0] KIND_ALU    = 3'd2;
    localparam logic [2:0] KIND_MEM    = 3'd3;
    localparam logic [2:0] KIND_ADDR   = 3'd4;
    localparam logic [2:0] KIND_BRANCH = 3'd5;
    localparam logic [2:0] KIND_BL     = 3'd6;

    // Single-halfword decode, packed as {valid, kind[2:0], imm[DATA_W-1:0]}.
    function automatic logic [DATA_W+3:0] decode16(input logic [15:0] h);
        logic              vld;
        logic [2:0]        kind;
        logic [DATA_W-1:0] imm;
        vld  = 1'b1;
        kind = KIND_NONE;
        imm  = {DATA_W{1'b0}};
        if (h[15:11] == 5'b00000) begin
            kind = KIND_SHIFT;
            imm  = DATA_W'(h[10:6]);
        end else if ((h[15:11] == 5'b00001) || (h[15:11] == 5'b00010)) begin
            kind = KIND_SHIFT;
            if (h[10:6] == 5'd0) begin
                imm = DATA_W'(6'd32);
            end else begin
                imm = DATA_W'(h[10:6]);
            end
        end else if (h[15:10] == 6'b000111) begin
            kind = KIND_ALU;
            imm  = DATA_W'(h[8:6]);
        end else if (h[15:13] == 3'b001) begin
            kind = KIND_ALU;
            imm  = DATA_W'(h[7:0]);
        end else if (h[15:6] == 10'b0100001001) begin
            kind = KIND_ALU;
            imm  = {DATA_W{1'b0}};
        end else if (h[15:12] == 4'b0110) begin
            kind = KIND_MEM;
            imm  = DATA_W'({h[10:6], 2'b00});
        end else if (h[15:12] == 4'b0111) begin
            kind = KIND_MEM;
            imm  = DATA_W'(h[10:6]);
        end else if (h[15:12] == 4'b1000) begin
            kind = KIND_MEM;
            imm  = DATA_W'({h[10:6], 1'b0});
        end else if (h[15:12] == 4'b1001) begin
            kind = KIND_MEM;
            imm  = DATA_W'({h[7:0], 2'b00});
        end else if (h[15:12] == 4'b1010) begin
            kind = KIND_ADDR;
            imm  = DATA_W'({h[7:0], 2'b00});
        end else if (h[15:8] == 8'b10110000) begin
            kind = KIND_ADDR;
            imm  = DATA_W'({h[6:0], 2'b00});
        end else if ((h[15:12] == 4'b1101) && (h[11:9] != 3'b111)) begin
            kind = KIND_BRANCH;
            imm  = DATA_W'($signed({h[7:0], 1'b0}));
        end else if (h[15:11] == 5'b11100) begin
            kind = KIND_BRANCH;
            imm  = DATA_W'($signed({h[10:0], 1'b0}));
        end else begin
            vld  = 1'b0;
            kind = KIND_NONE;
            imm  = {DATA_W{1'b0}};
        end
        return {vld, kind, imm};
    endfunction

    logic [0:0]        state_r,   state_nx_s;
    logic              pfx_s_r,   pfx_s_nx_s;
    logic [9:0]        pfx_imm_r, pfx_imm_nx_s;
    logic [DATA_W-1:0] imm_r,     imm_nx_s;
    logic              vld_r,     vld_nx_s;
    logic [2:0]        kind_r,    kind_nx_s;
    logic              err_r,     err_nx_s;

    logic              accept_s;
    logic              is_prefix_s;
    logic              is_suffix_s;
    logic [DATA_W+3:0] dec_s;
    logic [24:0]       bl_off_s;

    assign accept_s    = instr_valid_i && !stall_i && !flush_i;
    assign is_prefix_s = ENABLE_T32 && (instr_i[15:11] == 5'b11110);
    assign is_suffix_s = ENABLE_T32 && (instr_i[15:14] == 2'b11) && instr_i[12];
    assign dec_s       = decode16(instr_i);
    assign bl_off_s    = {pfx_s_r, ~(instr_i[13] ^ pfx_s_r), ~(instr_i[11] ^ pfx_s_r),
                          pfx_imm_r, instr_i[10:0], 1'b0};

    // Next-state and next-output selection: flush, then stall, then acceptance.
    always_comb begin
        state_nx_s   = state_r;
        pfx_s_nx_s   = pfx_s_r;
        pfx_imm_nx_s = pfx_imm_r;
        imm_nx_s     = imm_r;
        kind_nx_s    = kind_r;
        vld_nx_s     = 1'b0;
        err_nx_s     = 1'b0;
        if (flush_i) begin
            state_nx_s   = ST_IDLE;
            pfx_s_nx_s   = 1'b0;
            pfx_imm_nx_s = 10'd0;
            imm_nx_s     = {DATA_W{1'b0}};
            kind_nx_s    = KIND_NONE;
        end else if (stall_i) begin
            vld_nx_s = vld_r;
            err_nx_s = err_r;
        end else if (accept_s) begin
            imm_nx_s  = {DATA_W{1'b0}};
            kind_nx_s = KIND_NONE;
            case (state_r)
                ST_PAIR: begin
                    if (is_prefix_s) begin
                        pfx_s_nx_s   = instr_i[10];
                        pfx_imm_nx_s = instr_i[9:0];
                        err_nx_s     = 1'b1;
                    end else if (is_suffix_s) begin
                        state_nx_s   = ST_IDLE;
                        pfx_s_nx_s   = 1'b0;
                        pfx_imm_nx_s = 10'd0;
                        imm_nx_s     = DATA_W'($signed(bl_off_s));
                        kind_nx_s    = KIND_BL;
                        vld_nx_s     = 1'b1;
                    end else begin
                        state_nx_s   = ST_IDLE;
                        pfx_s_nx_s   = 1'b0;
                        pfx_imm_nx_s = 10'd0;
                        err_nx_s     = 1'b1;
                        vld_nx_s     = dec_s[DATA_W+3];
                        kind_nx_s    = dec_s[DATA_W+2:DATA_W];
                        imm_nx_s     = dec_s[DATA_W-1:0];
                    end
                end
                default: begin
                    if (is_prefix_s) begin
                        state_nx_s   = ST_PAIR;
                        pfx_s_nx_s   = instr_i[10];
                        pfx_imm_nx_s = instr_i[9:0];
                    end else if (dec_s[DATA_W+3]) begin
                        vld_nx_s  = 1'b1;
                        kind_nx_s = dec_s[DATA_W+2:DATA_W];
                        imm_nx_s  = dec_s[DATA_W-1:0];
                    end else if (is_suffix_s) begin
                        err_nx_s = 1'b1;
                    end else begin
                        err_nx_s = 1'b0;
                    end
                end
            endcase
        end else begin
            vld_nx_s = 1'b0;
            err_nx_s = 1'b0;
        end
    end

    // State, held prefix and registered outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r   <= ST_IDLE;
            pfx_s_r   <= 1'b0;
            pfx_imm_r <= 10'd0;
            imm_r     <= {DATA_W{1'b0}};
            kind_r    <= KIND_NONE;
            vld_r     <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            pfx_s_r   <= pfx_s_nx_s;
            pfx_imm_r <= pfx_imm_nx_s;
            imm_r     <= imm_nx_s;
            kind_r    <= kind_nx_s;
            vld_r     <= vld_nx_s;
            err_r     <= err_nx_s;
        end
    end

    assign imm_o         = imm_r;
    assign imm_kind_o    = kind_r;
    assign imm_valid_o   = vld_r;
    assign err_o         = err_r;
    assign t32_pending_o = (state_r == ST_PAIR);

endmodule

// File: tb/tb_thumb_imm_expander.sv
// Self-checking bench for thumb_imm_expander: directed scenarios plus a
// randomized stream compared against an arithmetic model of the decode rules.
module tb_thumb_imm_expander;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        instr_valid_i = 1'b0;
    logic [15:0] instr_i = 16'h0000;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] imm_o;
    logic        imm_valid_o;
    logic [2:0]  imm_kind_o;
    logic        t32_pending_o;
    logic        err_o;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state
    bit          m_pend;
    int          m_s, m_imm10;
    logic [31:0] m_imm;
    int          m_kind;
    bit          m_vld, m_err;

    thumb_imm_expander #(.DATA_W(32), .ENABLE_T32(1'b1)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .instr_valid_i(instr_valid_i),
        .instr_i(instr_i), .stall_i(stall_i), .flush_i(flush_i),
        .imm_o(imm_o), .imm_valid_o(imm_valid_o), .imm_kind_o(imm_kind_o),
        .t32_pending_o(t32_pending_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic model_reset();
        m_pend = 1'b0; m_s = 0; m_imm10 = 0;
        m_imm = 32'd0; m_kind = 0; m_vld = 1'b0; m_err = 1'b0;
    endtask

    // 16-bit immediate rules written as plain arithmetic on the halfword value.
    task automatic model_decode(input int h, output bit ok, output int kind, output int val);
        int imm5, off;
        imm5 = (h >> 6) & 31;
        ok = 1'b1; kind = 0; val = 0;
        if ((h >> 11) == 0) begin kind = 1; val = imm5; end
        else if ((h >> 11) == 1 || (h >> 11) == 2) begin kind = 1; val = (imm5 == 0) ? 32 : imm5; end
        else if ((h >> 10) == 7) begin kind = 2; val = (h >> 6) & 7; end
        else if ((h >> 13) == 1) begin kind = 2; val = h & 255; end
        else if ((h >> 6) == 265) begin kind = 2; val = 0; end
        else if ((h >> 12) == 6) begin kind = 3; val = imm5 * 4; end
        else if ((h >> 12) == 7) begin kind = 3; val = imm5; end
        else if ((h >> 12) == 8) begin kind = 3; val = imm5 * 2; end
        else if ((h >> 12) == 9) begin kind = 3; val = (h & 255) * 4; end
        else if ((h >> 12) == 10) begin kind = 4; val = (h & 255) * 4; end
        else if ((h >> 8) == 176) begin kind = 4; val = (h & 127) * 4; end
        else if ((h >> 12) == 13 && ((h >> 9) & 7) != 7) begin
            off = (h & 255) * 2; if (off >= 256) off -= 512; kind = 5; val = off;
        end else if ((h >> 11) == 28) begin
            off = (h & 2047) * 2; if (off >= 2048) off -= 4096; kind = 5; val = off;
        end else begin ok = 1'b0; end
    endtask

    // Advance the model by one clock edge with the given inputs.
    task automatic model_update(input bit f, input bit s, input bit v, input int h);
        bit ok, pre, suf;
        int k, val, j1, j2, off;
        if (f) begin
            model_reset();
        end else if (s) begin
            m_pend = m_pend;
        end else if (v) begin
            model_decode(h, ok, k, val);
            pre = ((h >> 11) == 30);
            suf = ((h >> 14) == 3) && (((h >> 12) & 1) == 1);
            m_err = 1'b0; m_vld = 1'b0; m_imm = 32'd0; m_kind = 0;
            if (pre) begin
                m_err = m_pend; m_pend = 1'b1;
                m_s = (h >> 10) & 1; m_imm10 = h & 1023;
            end else if (m_pend && suf) begin
                j1 = (h >> 13) & 1; j2 = (h >> 11) & 1;
                off = (m_s << 24) + ((1 - (j1 ^ m_s)) << 23) + ((1 - (j2 ^ m_s)) << 22)
                    + (m_imm10 << 12) + ((h & 2047) << 1);
                if (m_s == 1) off -= (1 << 25);
                m_imm = off; m_kind = 6; m_vld = 1'b1; m_pend = 1'b0;
            end else begin
                m_err = m_pend || (suf && !ok);
                m_pend = 1'b0;
                if (ok) begin m_imm = val; m_kind = k; m_vld = 1'b1; end
            end
        end else begin
            m_vld = 1'b0; m_err = 1'b0;
        end
    endtask

    task automatic step(input bit f, input bit s, input bit v, input logic [15:0] h);
        flush_i = f; stall_i = s; instr_valid_i = v; instr_i = h;
        @(posedge clk_i);
        model_update(f, s, v, int'(h));
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        #12;
        n_cmp += 5;
        if (imm_o !== 32'd0) begin n_bad++; $display("FAIL reset_imm got %h want 0", imm_o); end
        if (imm_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_vld got %b want 0", imm_valid_o); end
        if (imm_kind_o !== 3'd0) begin n_bad++; $display("FAIL reset_kind got %0d want 0", imm_kind_o); end
        if (t32_pending_o !== 1'b0) begin n_bad++; $display("FAIL reset_pend got %b want 0", t32_pending_o); end
        if (err_o !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err_o); end
        @(negedge clk_i); rst_n_i = 1'b1;
        step(1'b0, 1'b0, 1'b1, 16'h0880);
        n_cmp += 2;
        if (imm_o !== 32'd2 || imm_kind_o !== 3'd1) begin n_bad++; $display("FAIL lsr2 got %h/%0d want 2/1", imm_o, imm_kind_o); end
        if (imm_valid_o !== 1'b1) begin n_bad++; $display("FAIL lsr2_vld got %b want 1", imm_valid_o); end
    endtask

    task automatic test_shift();
        step(1'b0, 1'b0, 1'b1, 16'h0800);
        n_cmp++;
        if (imm_o !== 32'd32 || imm_kind_o !== 3'd1) begin n_bad++; $display("FAIL lsr32 got %h/%0d want 32/1", imm_o, imm_kind_o); end
    endtask

    task automatic test_mem_branch();
        step(1'b0, 1'b0, 1'b1, 16'h6848);
        n_cmp++;
        if (imm_o !== 32'd4 || imm_kind_o !== 3'd3) begin n_bad++; $display("FAIL ldr4 got %h/%0d want 4/3", imm_o, imm_kind_o); end
        step(1'b0, 1'b0, 1'b1, 16'hD0FE);
        n_cmp++;
        if (imm_o !== 32'hFFFFFFFC || imm_kind_o !== 3'd5) begin n_bad++; $display("FAIL bcond got %h/%0d want fffffffc/5", imm_o, imm_kind_o); end
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        n_cmp++;
        if (imm_valid_o !== 1'b0 || imm_o !== 32'hFFFFFFFC) begin n_bad++; $display("FAIL bubble_hold got %b/%h want 0/fffffffc", imm_valid_o, imm_o); end
    endtask

    task automatic test_bl_pair();
        step(1'b0, 1'b0, 1'b1, 16'hF7FF);
        n_cmp++;
        if (t32_pending_o !== 1'b1 || imm_valid_o !== 1'b0) begin n_bad++; $display("FAIL prefix got pend=%b vld=%b want 1/0", t32_pending_o, imm_valid_o); end
        step(1'b0, 1'b0, 1'b0, 16'h1234);
        step(1'b0, 1'b0, 1'b0, 16'h5678);
        n_cmp++;
        if (t32_pending_o !== 1'b1) begin n_bad++; $display("FAIL bubble_pend got %b want 1", t32_pending_o); end
        step(1'b0, 1'b0, 1'b1, 16'hFFFE);
        n_cmp += 2;
        if (imm_o !== 32'hFFFFFFFC || imm_kind_o !== 3'd6) begin n_bad++; $display("FAIL bl got %h/%0d want fffffffc/6", imm_o, imm_kind_o); end
        if (t32_pending_o !== 1'b0 || imm_valid_o !== 1'b1 || err_o !== 1'b0) begin n_bad++; $display("FAIL bl_flags got pend=%b vld=%b err=%b want 0/1/0", t32_pending_o, imm_valid_o, err_o); end
    endtask

    task automatic test_flush_pair();
        step(1'b0, 1'b0, 1'b1, 16'hF7FF);
        step(1'b1, 1'b0, 1'b1, 16'h0880);
        n_cmp++;
        if (t32_pending_o !== 1'b0 || imm_o !== 32'd0 || imm_kind_o !== 3'd0) begin n_bad++; $display("FAIL flush got pend=%b imm=%h kind=%0d want 0/0/0", t32_pending_o, imm_o, imm_kind_o); end
        step(1'b0, 1'b0, 1'b1, 16'hFFFE);
        n_cmp++;
        if (err_o !== 1'b1 || imm_valid_o !== 1'b0) begin n_bad++; $display("FAIL orphan got err=%b vld=%b want 1/0", err_o, imm_valid_o); end
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        n_cmp++;
        if (err_o !== 1'b0) begin n_bad++; $display("FAIL orphan_pulse got %b want 0", err_o); end
    endtask

    task automatic test_stall();
        step(1'b0, 1'b0, 1'b1, 16'h0880);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b1, 16'h6848);
            n_cmp++;
            if (imm_o !== 32'd2 || imm_kind_o !== 3'd1 || imm_valid_o !== 1'b1) begin n_bad++; $display("FAIL stall%0d got %h/%0d/%b want 2/1/1", i, imm_o, imm_kind_o, imm_valid_o); end
        end
        step(1'b0, 1'b0, 1'b1, 16'h6848);
        n_cmp++;
        if (imm_o !== 32'd4 || imm_kind_o !== 3'd3) begin n_bad++; $display("FAIL post_stall got %h/%0d want 4/3", imm_o, imm_kind_o); end
    endtask

    task automatic test_async_reset();
        step(1'b0, 1'b0, 1'b1, 16'hF000);
        n_cmp++;
        if (t32_pending_o !== 1'b1) begin n_bad++; $display("FAIL pre_rst got %b want 1", t32_pending_o); end
        instr_valid_i = 1'b0;
        #1 rst_n_i = 1'b0;
        #1;
        model_reset();
        n_cmp += 2;
        if (t32_pending_o !== 1'b0) begin n_bad++; $display("FAIL async_rst got %b want 0", t32_pending_o); end
        if (imm_o !== 32'd0 || imm_valid_o !== 1'b0) begin n_bad++; $display("FAIL async_rst_out got %h/%b want 0/0", imm_o, imm_valid_o); end
        @(negedge clk_i); rst_n_i = 1'b1;
        step(1'b0, 1'b0, 1'b1, 16'hF800);
        n_cmp++;
        if (err_o !== 1'b1 || t32_pending_o !== 1'b0) begin n_bad++; $display("FAIL post_rst got err=%b pend=%b want 1/0", err_o, t32_pending_o); end
    endtask

    task automatic test_random();
        logic [15:0] h;
        bit f, s, v;
        int sel;
        for (int i = 0; i < 3000; i++) begin
            sel = $urandom_range(0, 3);
            h = 16'($urandom);
            if (sel == 0) h[15:11] = 5'b11110;
            else if (sel == 1) begin h[15:14] = 2'b11; h[12] = 1'b1; end
            f = ($urandom_range(0, 15) == 0);
            s = ($urandom_range(0, 7) == 0);
            v = ($urandom_range(0, 3) != 0);
            step(f, s, v, h);
            n_cmp++;
            if (imm_o !== m_imm || imm_kind_o !== 3'(m_kind) || imm_valid_o !== m_vld
                || err_o !== m_err || t32_pending_o !== m_pend) begin
                n_bad++;
                $display("FAIL rand%0d h=%h got %h/%0d/v%b/e%b/p%b want %h/%0d/v%b/e%b/p%b",
                         i, h, imm_o, imm_kind_o, imm_valid_o, err_o, t32_pending_o,
                         m_imm, m_kind, m_vld, m_err, m_pend);
            end
        end
    endtask

    initial begin
        test_reset();
        test_shift();
        test_mem_branch();
        test_bl_pair();
        test_flush_pair();
        test_stall();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
